// File: rtl/seqdet_pkg.sv
// Shared types and sizing helpers for the "001" sequence-detector scan block.
package seqdet_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, REPORT} ctrl_state_t;

  typedef enum logic [1:0] {S0, S1, S2, S3} det_state_t;

  localparam int WORD_W_MIN = 4;
  localparam int WORD_W_MAX = 16;

  // Width needed to hold a detection count of 0..w.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seqdet_001_core.sv
// Moore "001" detector; det is a pure decode of the state register.
//
//   state | meaning
//   S0    | nothing useful seen (or last bit was 1)
//   S1    | seen "0"
//   S2    | seen "00" (stays here on further zeros)
//   S3    | seen "001" -> det = 1
module seqdet_001_core
  import seqdet_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic inp,
  output logic det
);

  det_state_t st;

  // Advance on en; rst and clr both force a clean start.
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S0;
    end else if (clr) begin
      st <= S0;
    end else if (en) begin
      case (st)
        S0: st <= inp ? S0 : S1;
        S1: st <= inp ? S0 : S2;
        S2: st <= inp ? S3 : S2;
        S3: st <= inp ? S0 : S1;
        default: st <= S0;
      endcase
    end
  end

  assign det = (st == S3);

endmodule

// File: rtl/seqdet_scan_ctrl.sv
// Scans one accepted word MSB-first through the "001" detector and reports
// the detection count plus a per-position mask.
//
//   state  | meaning
//   IDLE   | waiting for a word, in_ready = 1
//   SHIFT  | feeding WORD_W bits, one per cycle, MSB first
//   FLUSH  | one extra cycle to collect the last bit's detection
//   REPORT | result held until out_ready
module seqdet_scan_ctrl
  import seqdet_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = cnt_w(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_cont,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [WORD_W-1:0] out_mask
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORD_W - 1);

  ctrl_state_t       state;
  logic [WORD_W-1:0] data_q;
  logic [IDX_W-1:0]  bit_cnt;
  logic              accept;
  logic              det;
  logic              collect;

  assign accept = in_valid & in_ready;

  // The detector output lags its bit by one cycle, so detections are
  // collected from the second SHIFT cycle through FLUSH (WORD_W samples).
  assign collect = ((state == SHIFT) && (bit_cnt != LAST)) || (state == FLUSH);

  seqdet_001_core u_core (
    .clk (clk),
    .rst (rst),
    .clr (accept & ~in_cont),
    .en  (state == SHIFT),
    .inp (data_q[bit_cnt]),
    .det (det)
  );

  // Controller FSM with registered handshake and result outputs. bit_cnt
  // counts down and doubles as the index of the bit being fed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_q    <= '0;
      bit_cnt   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_count <= '0;
      out_mask  <= '0;
    end else begin
      // Mask fills by shifting left: the first bit's detection lands at MSB.
      if (collect) begin
        out_mask  <= {out_mask[WORD_W-2:0], det};
        out_count <= out_count + CNT_W'(det);
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            bit_cnt  <= LAST;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt == '0) begin
            state <= FLUSH;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        FLUSH: begin
          out_valid <= 1'b1;
          state     <= REPORT;
        end
        REPORT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_count <= '0;
            out_mask  <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seqdet_scan_ctrl.sv
// Directed bench for seqdet_scan_ctrl (WORD_W = 8).
module tb_seqdet_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_cont;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_count;
  logic [7:0] out_mask;

  int vec_cnt  = 0;
  int miscmp   = 0;
  int cyc      = 0;

  seqdet_scan_ctrl #(.WORD_W(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_cont   (in_cont),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_mask  (out_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer a word, wait for the result, check it, optionally hold it under
  // backpressure, then take it. Latency is counted in edges after the accept
  // edge: 8 SHIFT + 1 FLUSH -> out_valid seen after the 9th following edge,
  // i.e. the 10th edge counting the accept edge itself.
  task automatic run_word(input string tag, input logic [7:0] d, input logic c,
                          input logic [3:0] exp_cnt, input logic [7:0] exp_mask,
                          input int hold);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 30) begin @(negedge clk); n++; end
    chk({tag, " ready"}, in_ready, 1'b1);
    in_valid = 1'b1; in_data = d; in_cont = c;
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'h5A; in_cont = ~c;   // must be ignored now
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk); n++;
      in_data = 8'($urandom);
    end
    chk({tag, " latency"}, n, 9);
    chk({tag, " count"}, out_count, exp_cnt);
    chk({tag, " mask"}, out_mask, exp_mask);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, out_valid, 1'b1);
      chk({tag, " hold ready"}, in_ready, 1'b0);
      chk({tag, " hold count"}, out_count, exp_cnt);
      chk({tag, " hold mask"}, out_mask, exp_mask);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " taken ready"}, in_ready, 1'b1);
    chk({tag, " taken valid"}, out_valid, 1'b0);
    chk({tag, " taken count"}, out_count, 4'd0);
  endtask

  // Accept word d, then assert rst during SHIFT cycle 4.
  task automatic mid_reset(input string tag, input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_cont = 1'b0;
    @(negedge clk);                        // SHIFT cycle 0
    in_valid = 1'b0;
    repeat (4) @(negedge clk);             // SHIFT cycle 4
    rst = 1'b1;
    out_ready = 1'b1;                      // must not matter under reset
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    chk({tag, " rst ready"}, in_ready, 1'b1);
    chk({tag, " rst valid"}, out_valid, 1'b0);
    chk({tag, " rst count"}, out_count, 4'd0);
    chk({tag, " rst mask"}, out_mask, 8'd0);
    begin
      int seen = 0;
      repeat (12) begin @(negedge clk); if (out_valid) seen++; end
      chk({tag, " no stray valid"}, seen, 0);
    end
  endtask

  initial begin
    int t[3];
    int k;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_cont = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset ready", in_ready, 1'b1);
    chk("reset valid", out_valid, 1'b0);
    chk("reset count", out_count, 4'd0);
    chk("reset mask", out_mask, 8'd0);

    run_word("basic", 8'b00100100, 1'b0, 4'd2, 8'b00100100, 0);
    run_word("all ones", 8'hFF, 1'b0, 4'd0, 8'h00, 0);
    run_word("all zeros", 8'h00, 1'b0, 4'd0, 8'h00, 0);
    run_word("alt", 8'b01001001, 1'b0, 4'd2, 8'b00001001, 0);
    run_word("dense", 8'b00100101, 1'b0, 4'd2, 8'b00100100, 0);

    run_word("carry w1", 8'b11111100, 1'b0, 4'd0, 8'h00, 0);
    run_word("carry w2", 8'b10000000, 1'b1, 4'd1, 8'b10000000, 0);
    run_word("nocarry w1", 8'b11111100, 1'b0, 4'd0, 8'h00, 0);
    run_word("nocarry w2", 8'b10000000, 1'b0, 4'd0, 8'h00, 0);

    run_word("backpressure", 8'b00100100, 1'b0, 4'd2, 8'b00100100, 5);

    mid_reset("rstA", 8'h00);
    run_word("after rstA", 8'b00100100, 1'b1, 4'd2, 8'b00100100, 0);
    // Word 0x00 leaves the detector in S2 before reset; a "1" with carry-over
    // would detect unless reset returned it to S0.
    mid_reset("rstB", 8'h00);
    run_word("after rstB", 8'b10000000, 1'b1, 4'd0, 8'h00, 0);

    // Back-to-back with both handshakes tied high.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'b00100100; in_cont = 1'b0;
    k = 0;
    for (int i = 0; i < 60 && k < 3; i++) begin
      @(negedge clk);
      if (out_valid) begin
        t[k] = cyc;
        chk("b2b count", out_count, 4'd2);
        k++;
      end
    end
    in_valid = 1'b0;
    chk("b2b results", k, 3);
    if (k == 3) begin
      chk("b2b gap1", t[1] - t[0], 11);
      chk("b2b gap2", t[2] - t[1], 11);
    end
    repeat (15) @(negedge clk);
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
